// File: rtl/btn_step_conditioner.sv
// Two-channel push-button conditioner: 2-flop sync, debounce, press strobe.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat strobes per channel.
module btn_step_conditioner #(
  parameter int unsigned DEB_CYCLES    = 500_000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter logic        BTN_ACTIVE    = 1'b1
) (
  input  logic clk,
  input  logic rb,
  input  logic bt_up_i,
  input  logic bt_dn_i,
  output logic up_stb,
  output logic dn_stb,
  output logic up_held,
  output logic dn_held
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [1:0] w_stable;
  logic       w_both;
  assign w_both = &w_stable;
`endif

  // Bit 0 = up channel, bit 1 = down channel; raw levels normalised so 1 = pressed.
  logic [1:0] w_raw;
  logic [1:0] w_held;
  logic [1:0] w_rise;
  logic [1:0] w_due;
  logic [1:0] r_stb;

  assign w_raw = {bt_dn_i, bt_up_i} ^ {2{~BTN_ACTIVE}};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_held;
    logic             r_held_q;
    logic [DEB_W-1:0] r_deb_cnt;

    // Synchronizer, debounce counter and press-edge pipeline.
    always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_stable  <= 1'b0;
        r_held    <= 1'b0;
        r_held_q  <= 1'b0;
        r_deb_cnt <= '0;
      end else begin
        r_sync1  <= w_raw[g];
        r_sync2  <= r_sync1;
        r_held   <= r_stable;
        r_held_q <= r_held;
        if (r_sync2 == r_stable) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          r_stable  <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end
    end

    assign w_held[g] = r_held;
    assign w_rise[g] = r_held & ~r_held_q;

`ifdef BTN_AUTOREPEAT_EN
    rpt_state_e       r_rpt_state;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_abort;
    logic             w_fire;

    assign w_stable[g] = r_stable;
    // Release or a two-button chord cancels any pending repeat.
    assign w_abort = ~r_stable | w_both;
    assign w_fire  = ~w_abort &
                     (((r_rpt_state == RPT_DELAY)  && (r_rpt_cnt == RPT_DELAY_LAST)) ||
                      ((r_rpt_state == RPT_REPEAT) && (r_rpt_cnt == RPT_PERIOD_LAST)));

    always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
        r_rpt_state <= RPT_IDLE;
        r_rpt_cnt   <= '0;
      end else if (w_abort) begin
        r_rpt_state <= RPT_IDLE;
        r_rpt_cnt   <= '0;
      end else begin
        case (r_rpt_state)
          RPT_IDLE: begin
            r_rpt_cnt <= '0;
            if (w_rise[g]) r_rpt_state <= RPT_DELAY;
          end
          RPT_DELAY: begin
            if (r_rpt_cnt == RPT_DELAY_LAST) begin
              r_rpt_state <= RPT_REPEAT;
              r_rpt_cnt   <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (r_rpt_cnt == RPT_PERIOD_LAST) r_rpt_cnt <= '0;
            else                              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
          end
          default: begin
            r_rpt_state <= RPT_IDLE;
            r_rpt_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_due[g] = w_rise[g] | w_fire;
`else
    assign w_due[g] = w_rise[g];
`endif
  end

  // Strobes due on both channels in the same cycle cancel each other.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) r_stb <= 2'b00;
    else     r_stb <= (w_due == 2'b11) ? 2'b00 : w_due;
  end

  assign up_stb  = r_stb[0];
  assign dn_stb  = r_stb[1];
  assign up_held = w_held[0];
  assign dn_held = w_held[1];

endmodule
